// File: rtl/gate_reduce_unit_if.sv
// Valid/ready stream bundle for gate_reduce_unit: beat input side plus reduced-result output side.
// The master modport is the producer/consumer environment; the slave modport is the unit.
interface gate_reduce_unit_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
);
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_beats;
  logic             out_overflow;

  modport master (
    output op, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_overflow
  );

  modport slave (
    input  op, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_overflow
  );
endinterface

// File: rtl/gate_reduce_unit.sv
// Folds a burst of WIDTH-bit beats with a runtime-selected AND/OR/XOR/NAND op
// and presents one registered result per burst on a valid/ready output.
module gate_reduce_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input logic            clk,
  input logic            rst,
  gate_reduce_unit_if.slave bus
);
  localparam int unsigned     CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCUM = 2'b01, DONE = 2'b10} state_t;

  state_t           state, state_n;
  op_t              op_q, op_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ready_q, valid_q;
  logic [WIDTH-1:0] data_q, data_n;
  logic [CNT_W-1:0] beats_q, beats_n;
  logic             ovf_q, ovf_n;
  logic             accept;
  logic             close;

  assign accept = bus.in_valid && ready_q;

  // Next-state, accumulator and result-load logic
  always_comb begin
    state_n = state;
    op_n    = op_q;
    acc_n   = acc;
    cnt_n   = cnt;
    data_n  = data_q;
    beats_n = beats_q;
    ovf_n   = ovf_q;
    close   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          acc_n   = bus.in_data;
          op_n    = op_t'(bus.op);
          cnt_n   = CNT_ONE;
          close   = bus.in_last || (MAX_BEATS == 1);
          state_n = close ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          case (op_q)
            OP_OR:   acc_n = acc | bus.in_data;
            OP_XOR:  acc_n = acc ^ bus.in_data;
            default: acc_n = acc & bus.in_data;
          endcase
          cnt_n   = cnt + CNT_ONE;
          close   = bus.in_last || (cnt_n == CNT_MAX);
          state_n = close ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // NAND shares the AND fold; inversion happens once at result load
    if (close) begin
      data_n  = (op_n == OP_NAND) ? ~acc_n : acc_n;
      beats_n = cnt_n;
      ovf_n   = (cnt_n == CNT_MAX) && !bus.in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_AND;
      acc     <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      ready_q <= (state_n != DONE);
      valid_q <= (state_n == DONE);
      data_q  <= data_n;
      beats_q <= beats_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_data     = data_q;
  assign bus.out_beats    = beats_q;
  assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_gate_reduce_unit.sv
// Bench for gate_reduce_unit: directed vector table, hand-written corner sequences,
// and randomized bursts checked against a per-bit counting reference model.
module tb_gate_reduce_unit;
  localparam int unsigned W  = 8;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_reduce_unit_if #(.WIDTH(W), .MAX_BEATS(MB)) bus ();
  gate_reduce_unit #(.WIDTH(W), .MAX_BEATS(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]      op;
    int              n;
    logic [3:0][7:0] d;
    logic            lst;
    logic [7:0]      ed;
    int              eb;
    logic            eo;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-bit popcount across the burst decides each result bit
  function automatic logic [7:0] ref_reduce(input logic [1:0] o, input int n, input logic [3:0][7:0] d);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(d[k][b]);
      case (o)
        2'b00:   r[b] = (ones == n);
        2'b01:   r[b] = (ones > 0);
        2'b10:   r[b] = ones[0];
        default: r[b] = !(ones == n);
      endcase
    end
    return r;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic lst, input logic [1:0] o);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = lst;
    bus.op       = o;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_last  = 1'($urandom);
    bus.op       = 2'($urandom);
  endtask

  task automatic drive_burst(input logic [1:0] o, input int n, input logic [3:0][7:0] d,
                             input logic lst, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      if (k == 0)      send_beat(d[k], lst && (k == n - 1), o);
      else if (gaps)   send_beat(d[k], lst && (k == n - 1), 2'($urandom));
      else             send_beat(d[k], lst && (k == n - 1), o ^ 2'b10);
    end
  endtask

  task automatic take_result(input string nm, input logic [7:0] ed, input int eb,
                             input logic eo, input int hold);
    chk({nm, "_valid"},    32'(bus.out_valid), 32'd1);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_data"},     32'(bus.out_data), 32'(ed));
    chk({nm, "_beats"},    32'(bus.out_beats), 32'(eb));
    chk({nm, "_ovf"},      32'(bus.out_overflow), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({nm, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, "_hold_rdy"},   32'(bus.in_ready), 32'd0);
      chk({nm, "_hold_data"},  32'(bus.out_data), 32'(ed));
      chk({nm, "_hold_beats"}, 32'(bus.out_beats), 32'(eb));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({nm, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_post_rdy"},   32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b00, 3, {8'h00, 8'h3C, 8'h0F, 8'hFF}, 1'b1, 8'h0C, 3, 1'b0};
    vt[1] = '{2'b01, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, 1'b1, 8'hA5, 1, 1'b0};
    vt[2] = '{2'b10, 4, {8'h08, 8'h04, 8'h02, 8'h01}, 1'b0, 8'h0F, 4, 1'b1};
    vt[3] = '{2'b11, 2, {8'h00, 8'h00, 8'hFF, 8'hF0}, 1'b1, 8'h0F, 2, 1'b0};
    vt[4] = '{2'b01, 4, {8'h80, 8'h20, 8'h10, 8'h01}, 1'b1, 8'hB1, 4, 1'b0};
    vt[5] = '{2'b10, 2, {8'h00, 8'h00, 8'h55, 8'hAA}, 1'b1, 8'hFF, 2, 1'b0};
    vt[6] = '{2'b11, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'hFF, 1, 1'b0};

    rst = 1'b1;
    bus.op = 2'b00; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_data",     32'(bus.out_data), 32'd0);
    chk("rst_beats",    32'(bus.out_beats), 32'd0);
    chk("rst_ovf",      32'(bus.out_overflow), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      drive_burst(vt[i].op, vt[i].n, vt[i].d, vt[i].lst, 1'b0);
      take_result($sformatf("vec%0d", i), vt[i].ed, vt[i].eb, vt[i].eo, 0);
    end

    // Overflow close with the next beat held by the source until after the handshake
    drive_burst(2'b10, 4, {8'h08, 8'h04, 8'h02, 8'h01}, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'h10; bus.in_last = 1'b1; bus.op = 2'b01;
    chk("ovf_valid", 32'(bus.out_valid), 32'd1);
    chk("ovf_data",  32'(bus.out_data), 32'h0F);
    chk("ovf_beats", 32'(bus.out_beats), 32'd4);
    chk("ovf_flag",  32'(bus.out_overflow), 32'd1);
    chk("ovf_rdy0",  32'(bus.in_ready), 32'd0);
    step();
    step();
    chk("ovf_held_rdy", 32'(bus.in_ready), 32'd0);
    chk("ovf_held_data", 32'(bus.out_data), 32'h0F);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("ovf_idle_rdy",   32'(bus.in_ready), 32'd1);
    chk("ovf_idle_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    take_result("ovf_next", 8'h10, 1, 1'b0, 0);

    // Backpressure: result held for five cycles
    drive_burst(2'b00, 3, {8'h00, 8'h3C, 8'h0F, 8'hFF}, 1'b1, 1'b0);
    take_result("bp", 8'h0C, 3, 1'b0, 5);

    // Asynchronous reset in the middle of a burst
    drive_burst(2'b01, 2, {8'h00, 8'h00, 8'h12, 8'h34}, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdy",   32'(bus.in_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.out_data), 32'd0);
    chk("mid_rst_beats", 32'(bus.out_beats), 32'd0);
    chk("mid_rst_ovf",   32'(bus.out_overflow), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_release_rdy", 32'(bus.in_ready), 32'd1);
    drive_burst(2'b00, 1, {8'h00, 8'h00, 8'h00, 8'h33}, 1'b1, 1'b0);
    take_result("after_rst", 8'h33, 1, 1'b0, 0);

    // Randomized bursts against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [1:0]      o;
      logic            lst;
      int              n;
      logic [3:0][7:0] d;
      o   = 2'($urandom);
      lst = 1'($urandom);
      n   = lst ? int'($urandom_range(1, MB)) : int'(MB);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      drive_burst(o, n, d, lst, 1'b1);
      take_result($sformatf("rand%0d", t), ref_reduce(o, n, d), n, !lst, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
